// File: rtl/ud_counter_mod.sv
// ud_counter_mod: up/down counter with programmable inclusive limit, load, enable and wrap/saturate bounds
module ud_counter_mod #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);
    logic [WIDTH-1:0] r_count, w_next;
    logic             r_wrap, w_wrap;
    // Bound checks come before +/-1, so the arithmetic never overflows
    always_comb begin
        w_next = r_count;
        w_wrap = 1'b0;
        if (load)
            w_next = (load_val > limit) ? limit : load_val;
        else if (!en)
            w_next = r_count;
        else if (r_count > limit)
            w_next = limit;
        else if (up_dn) begin
            if (r_count < limit)
                w_next = r_count + 1'b1;
            else if (!sat) begin
                w_next = '0;
                w_wrap = 1'b1;
            end
        end else begin
            if (r_count != '0)
                w_next = r_count - 1'b1;
            else if (!sat) begin
                w_next = limit;
                w_wrap = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RESET_VAL;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_wrap;
        end
    end
    assign count  = r_count;
    assign wrap   = r_wrap;
    assign at_max = (r_count == limit);
    assign at_min = (r_count == '0);
endmodule
